// File: rtl/uart_rx_pkg.sv
`default_nettype none
// uart_rx_pkg: shared state encoding, format limits and FIFO word layout for the UART receiver.
// Rev 1.0
package uart_rx_pkg;

   typedef enum logic [6:0] {
      ST_IDLE   = 7'b0000001,
      ST_START  = 7'b0000010,
      ST_DATA   = 7'b0000100,
      ST_PARITY = 7'b0001000,
      ST_STOP1  = 7'b0010000,
      ST_STOP2  = 7'b0100000,
      ST_BREAK  = 7'b1000000
   } rx_state_t;

   localparam logic [3:0] c_DATA_BITS_MIN = 4'd5;
   localparam logic [3:0] c_DATA_BITS_MAX = 4'd9;
   localparam logic [3:0] c_ACQ_NUM_MIN   = 4'd4;

   // Flag positions above the data field of a stored word
   localparam int c_WORD_PERR_OFS = 0;
   localparam int c_WORD_FERR_OFS = 1;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// uart_rx_fifo: first-word-fall-through FIFO with level, full/empty, sticky overflow and flush.
// Rev 1.0
module uart_rx_fifo #(
   parameter int WIDTH   = 11,
   parameter int DEPTH   = 64,
   parameter int LEVEL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clr,
   input  logic               i_wr,
   input  logic [WIDTH-1:0]   i_wdata,
   input  logic               i_rd,
   output logic [WIDTH-1:0]   o_rdata,
   output logic               o_empty,
   output logic               o_full,
   output logic               o_over,
   output logic [LEVEL_W-1:0] o_level
);
   localparam int               c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]    c_FULL = (c_AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wp, r_rp;
   logic [c_AW:0]    r_cnt;
   logic             r_over;
   logic             w_empty, w_full, w_rd, w_wr;

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == c_FULL);
   assign w_rd    = i_rd && !w_empty;
   // A read in the same cycle frees the slot, so a write into a full FIFO is still accepted
   assign w_wr    = i_wr && (!w_full || w_rd);

   always_ff @(posedge clk) begin
      if (w_wr && !i_clr)
         r_mem[r_wp] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_over <= 1'b0;
      end else if (i_clr) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_over <= 1'b0;
      end else begin
         if (w_wr)
            r_wp <= r_wp + 1'b1;
         if (w_rd)
            r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + (c_AW+1)'(w_wr) - (c_AW+1)'(w_rd);
         if (i_wr && !w_wr)
            r_over <= 1'b1;
      end
   end

   assign o_rdata = w_empty ? '0 : r_mem[r_rp];
   assign o_empty = w_empty;
   assign o_full  = w_full;
   assign o_over  = r_over;
   assign o_level = LEVEL_W'(r_cnt);

endmodule
`default_nettype wire

// File: rtl/uart_rx_core_v3.sv
`default_nettype none
// uart_rx_core_v3: oversampling UART receiver with runtime frame format and FWFT receive FIFO.
// Rev 1.0
module uart_rx_core_v3
   import uart_rx_pkg::*;
#(
   parameter int MAX_DATA_BITS = 9,
   parameter int FIFO_DEPTH    = 64,
   parameter int LEVEL_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     p_Enable_i,
   input  logic                     AcqSig_i,
   input  logic [3:0]               AcqNumPerBit_i,
   input  logic [3:0]               DataBits_i,
   input  logic                     p_ParityEnable_i,
   input  logic                     ParityMethod_i,
   input  logic                     p_TwoStop_i,
   input  logic                     p_BigEnd_i,
   input  logic                     Rx_i,
   input  logic                     n_Rd_i,
   input  logic                     n_Clr_i,
   output logic [MAX_DATA_BITS-1:0] Data_o,
   output logic                     p_HeadParityErr_o,
   output logic                     p_HeadFrameErr_o,
   output logic                     p_Empty_o,
   output logic                     p_Full_o,
   output logic                     p_Over_o,
   output logic                     p_Break_o,
   output logic [LEVEL_W-1:0]       RxFifoLevel_o,
   output logic                     Byte_Synch_o
);
   localparam int         c_WW     = MAX_DATA_BITS + 2;
   localparam logic [3:0] c_DB_MAX = (MAX_DATA_BITS < 9) ? 4'(MAX_DATA_BITS) : c_DATA_BITS_MAX;

   rx_state_t              r_state, w_next;
   logic [1:0]             r_sync;
   logic                   r_rxs_d;
   logic [3:0]             r_n, r_dbits, r_cnt, r_bitidx;
   logic                   r_par_en, r_par_odd, r_two, r_big, r_parbit;
   logic [2:0]             r_samp;
   logic [MAX_DATA_BITS-1:0] r_data;
   logic                   r_wr, r_synch, r_break;
   logic [c_WW-1:0]        r_word;
   logic [c_WW-1:0]        w_head;

   logic                   w_rxs, w_fall, w_last, w_maj, w_perr, w_complete, w_brk;
   logic [3:0]             w_mid, w_pos;
   logic [2:0]             w_samp;

   assign w_rxs  = r_sync[1];
   assign w_fall = p_Enable_i & r_rxs_d & ~w_rxs;

   // The third sample can land on the resolving tick, so the vote sees the live value
   always_comb begin
      w_mid  = r_n >> 1;
      w_last = (r_cnt == r_n - 4'd1);
      for (int k = 0; k < 3; k++)
         w_samp[k] = (AcqSig_i && (r_cnt == w_mid - 4'd1 + 4'(k))) ? w_rxs : r_samp[k];
      w_maj  = (w_samp[0] & w_samp[1]) | (w_samp[0] & w_samp[2]) | (w_samp[1] & w_samp[2]);
      w_pos  = r_big ? (r_dbits - 4'd1 - r_bitidx) : r_bitidx;
      w_perr = r_par_en & (^r_data ^ r_par_odd ^ r_parbit);
   end

   always_comb begin
      w_next     = r_state;
      w_complete = 1'b0;
      w_brk      = 1'b0;
      case (r_state)
         ST_IDLE:   if (w_fall) w_next = ST_START;
         ST_START:  if (AcqSig_i && w_last) w_next = w_maj ? ST_IDLE : ST_DATA;
         ST_DATA:   if (AcqSig_i && w_last && (r_bitidx == r_dbits - 4'd1))
                       w_next = r_par_en ? ST_PARITY : ST_STOP1;
         ST_PARITY: if (AcqSig_i && w_last) w_next = ST_STOP1;
         ST_STOP1:  if (AcqSig_i && w_last) begin
                       if (!w_maj && (r_data == '0) && (!r_par_en || !r_parbit)) begin
                          w_next = ST_BREAK;
                          w_brk  = 1'b1;
                       end else if (r_two && w_maj) begin
                          w_next = ST_STOP2;
                       end else begin
                          w_next     = ST_IDLE;
                          w_complete = 1'b1;
                       end
                    end
         ST_STOP2:  if (AcqSig_i && w_last) begin
                       w_next     = ST_IDLE;
                       w_complete = 1'b1;
                    end
         ST_BREAK:  if (w_rxs && AcqSig_i && w_last) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
      if (!p_Enable_i) begin
         w_next     = ST_IDLE;
         w_complete = 1'b0;
         w_brk      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_sync    <= 2'b11;
         r_rxs_d   <= 1'b1;
         r_n       <= c_ACQ_NUM_MIN;
         r_dbits   <= c_DATA_BITS_MIN;
         r_par_en  <= 1'b0;
         r_par_odd <= 1'b0;
         r_two     <= 1'b0;
         r_big     <= 1'b0;
         r_parbit  <= 1'b0;
         r_cnt     <= '0;
         r_bitidx  <= '0;
         r_samp    <= 3'b111;
         r_data    <= '0;
         r_wr      <= 1'b0;
         r_synch   <= 1'b0;
         r_break   <= 1'b0;
         r_word    <= '0;
      end else begin
         r_sync  <= {r_sync[0], Rx_i};
         r_rxs_d <= w_rxs;
         r_state <= w_next;
         r_wr    <= w_complete;
         r_synch <= w_complete;
         if (w_complete) begin
            r_word                                   <= {2'b00, r_data};
            r_word[MAX_DATA_BITS + c_WORD_FERR_OFS] <= ~w_maj;
            r_word[MAX_DATA_BITS + c_WORD_PERR_OFS] <= w_perr;
         end
         if (r_state == ST_IDLE) begin
            // Format is captured continuously while idle and frozen for the frame
            r_n       <= (AcqNumPerBit_i < c_ACQ_NUM_MIN) ? c_ACQ_NUM_MIN : AcqNumPerBit_i;
            r_dbits   <= (DataBits_i < c_DATA_BITS_MIN) ? c_DATA_BITS_MIN :
                         (DataBits_i > c_DB_MAX) ? c_DB_MAX : DataBits_i;
            r_par_en  <= p_ParityEnable_i;
            r_par_odd <= ParityMethod_i;
            r_two     <= p_TwoStop_i;
            r_big     <= p_BigEnd_i;
            r_parbit  <= 1'b0;
            r_cnt     <= '0;
            r_bitidx  <= '0;
            r_samp    <= 3'b111;
            r_data    <= '0;
         end else if (r_state == ST_BREAK) begin
            if (!w_rxs)
               r_cnt <= '0;
            else if (AcqSig_i)
               r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
         end else if (AcqSig_i) begin
            r_samp <= w_samp;
            if (w_last) begin
               r_cnt <= '0;
               if (r_state == ST_DATA) begin
                  for (int i = 0; i < MAX_DATA_BITS; i++)
                     if (4'(i) == w_pos) r_data[i] <= w_maj;
                  r_bitidx <= r_bitidx + 4'd1;
               end
               if (r_state == ST_PARITY)
                  r_parbit <= w_maj;
            end else begin
               r_cnt <= r_cnt + 4'd1;
            end
         end
         if (w_brk)
            r_break <= 1'b1;
         else if (!n_Clr_i)
            r_break <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .WIDTH   (c_WW),
      .DEPTH   (FIFO_DEPTH),
      .LEVEL_W (LEVEL_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (~n_Clr_i),
      .i_wr    (r_wr),
      .i_wdata (r_word),
      .i_rd    (~n_Rd_i),
      .o_rdata (w_head),
      .o_empty (p_Empty_o),
      .o_full  (p_Full_o),
      .o_over  (p_Over_o),
      .o_level (RxFifoLevel_o)
   );

   assign Data_o            = w_head[MAX_DATA_BITS-1:0];
   assign p_HeadParityErr_o = w_head[MAX_DATA_BITS + c_WORD_PERR_OFS];
   assign p_HeadFrameErr_o  = w_head[MAX_DATA_BITS + c_WORD_FERR_OFS];
   assign p_Break_o         = r_break;
   assign Byte_Synch_o      = r_synch;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core_v3.sv
`timescale 1ns/1ps
`default_nettype none
// tb_uart_rx_core_v3: directed and randomized frames against a frame-level reference model.
// Rev 1.0
module tb_uart_rx_core_v3;
   localparam int MDB  = 9;
   localparam int DEPTH = 4;
   localparam int LW   = 16;
   localparam int NDIR = 15;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           p_Enable_i = 1'b1;
   logic           AcqSig_i = 1'b0;
   logic [3:0]     AcqNumPerBit_i = 4'(NDIR);
   logic [3:0]     DataBits_i = 4'd8;
   logic           p_ParityEnable_i = 1'b0;
   logic           ParityMethod_i = 1'b0;
   logic           p_TwoStop_i = 1'b0;
   logic           p_BigEnd_i = 1'b0;
   logic           Rx_i = 1'b1;
   logic           n_Rd_i = 1'b1;
   logic           n_Clr_i = 1'b1;
   logic [MDB-1:0] Data_o;
   logic           p_HeadParityErr_o, p_HeadFrameErr_o, p_Empty_o, p_Full_o, p_Over_o, p_Break_o;
   logic [LW-1:0]  RxFifoLevel_o;
   logic           Byte_Synch_o;

   int vec = 0;
   int miss = 0;
   int sync_cnt = 0;
   int div = 0;

   uart_rx_core_v3 #(.MAX_DATA_BITS(MDB), .FIFO_DEPTH(DEPTH), .LEVEL_W(LW)) dut (
      .clk(clk), .rst(rst), .p_Enable_i(p_Enable_i), .AcqSig_i(AcqSig_i),
      .AcqNumPerBit_i(AcqNumPerBit_i), .DataBits_i(DataBits_i),
      .p_ParityEnable_i(p_ParityEnable_i), .ParityMethod_i(ParityMethod_i),
      .p_TwoStop_i(p_TwoStop_i), .p_BigEnd_i(p_BigEnd_i), .Rx_i(Rx_i),
      .n_Rd_i(n_Rd_i), .n_Clr_i(n_Clr_i), .Data_o(Data_o),
      .p_HeadParityErr_o(p_HeadParityErr_o), .p_HeadFrameErr_o(p_HeadFrameErr_o),
      .p_Empty_o(p_Empty_o), .p_Full_o(p_Full_o), .p_Over_o(p_Over_o),
      .p_Break_o(p_Break_o), .RxFifoLevel_o(RxFifoLevel_o), .Byte_Synch_o(Byte_Synch_o)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      AcqSig_i = (div == 0);
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (Byte_Synch_o === 1'b1) sync_cnt++;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog expired: got timeout, want $finish");
      $fatal(1);
   end

   task automatic wait_tick();
      do @(posedge clk); while (AcqSig_i !== 1'b1);
      @(negedge clk);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int ticks);
      Rx_i = 1'b1;
      repeat (ticks) wait_tick();
      wait_clks(3);
   endtask

   task automatic pop();
      n_Rd_i = 1'b0; @(negedge clk); n_Rd_i = 1'b1; @(negedge clk);
   endtask

   task automatic clr();
      n_Clr_i = 1'b0; @(negedge clk); n_Clr_i = 1'b1; @(negedge clk);
   endtask

   task automatic set_fmt(input int n, input int db, input bit pe, input bit po, input bit two, input bit big);
      AcqNumPerBit_i = 4'(n); DataBits_i = 4'(db); p_ParityEnable_i = pe;
      ParityMethod_i = po; p_TwoStop_i = two; p_BigEnd_i = big;
      wait_clks(2);
   endtask

   // Serialises one frame; each bit lasts n ticks; tick 'noise' of every bit is inverted
   task automatic send_frame(input logic [8:0] d, input int nb, input bit pe, input bit po,
                             input bit big, input bit two, input bit badp, input bit s1,
                             input bit s2, input int n, input int noise, input int drop);
      bit q[$];
      logic [8:0] dm;
      dm = d & 9'((1 << nb) - 1);
      q.push_back(1'b0);
      for (int i = 0; i < nb; i++) q.push_back(dm[big ? nb - 1 - i : i]);
      if (pe) q.push_back(^dm ^ po ^ badp);
      q.push_back(s1);
      if (two) q.push_back(s2);
      wait_tick();
      foreach (q[i]) begin
         if (i == drop) p_Enable_i = 1'b0;
         for (int t = 1; t <= n; t++) begin
            Rx_i = (t == noise) ? ~q[i] : q[i];
            wait_tick();
         end
      end
      Rx_i = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      wait_clks(3);
      vec++; if (Data_o !== '0) begin miss++; $display("FAIL reset_data got %h want 0", Data_o); end
      vec++; if ({p_HeadParityErr_o, p_HeadFrameErr_o, p_Full_o, p_Over_o, p_Break_o, Byte_Synch_o} !== 6'b0) begin
         miss++; $display("FAIL reset_flags got %b want 000000",
            {p_HeadParityErr_o, p_HeadFrameErr_o, p_Full_o, p_Over_o, p_Break_o, Byte_Synch_o}); end
      vec++; if (p_Empty_o !== 1'b1) begin miss++; $display("FAIL reset_empty got %b want 1", p_Empty_o); end
      vec++; if (RxFifoLevel_o !== '0) begin miss++; $display("FAIL reset_level got %0d want 0", RxFifoLevel_o); end
      rst = 1'b1;
      wait_clks(3);
   endtask

   task automatic test_8n1();
      int s0;
      set_fmt(NDIR, 8, 0, 0, 0, 0);
      s0 = sync_cnt;
      send_frame(9'h0A5, 8, 0, 0, 0, 0, 0, 1, 1, NDIR, 0, -1);
      idle(2);
      vec++; if (Data_o !== 9'h0A5) begin miss++; $display("FAIL 8n1_data got %h want 0a5", Data_o); end
      vec++; if ({p_HeadFrameErr_o, p_HeadParityErr_o} !== 2'b00) begin miss++;
         $display("FAIL 8n1_flags got %b want 00", {p_HeadFrameErr_o, p_HeadParityErr_o}); end
      vec++; if (RxFifoLevel_o !== 16'd1) begin miss++; $display("FAIL 8n1_level got %0d want 1", RxFifoLevel_o); end
      vec++; if (sync_cnt !== s0 + 1) begin miss++; $display("FAIL 8n1_synch got %0d want %0d", sync_cnt - s0, 1); end
      pop();
      vec++; if (p_Empty_o !== 1'b1) begin miss++; $display("FAIL 8n1_pop_empty got %b want 1", p_Empty_o); end
   endtask

   task automatic test_9o2_msb();
      set_fmt(NDIR, 9, 1, 1, 1, 1);
      send_frame(9'h1C3, 9, 1, 1, 1, 1, 1, 1, 1, NDIR, 0, -1);
      idle(2);
      vec++; if (Data_o !== 9'h1C3) begin miss++; $display("FAIL 9o2_data got %h want 1c3", Data_o); end
      vec++; if ({p_HeadFrameErr_o, p_HeadParityErr_o} !== 2'b01) begin miss++;
         $display("FAIL 9o2_flags got %b want 01", {p_HeadFrameErr_o, p_HeadParityErr_o}); end
      pop();
   endtask

   task automatic test_glitch();
      int s0;
      set_fmt(NDIR, 8, 0, 0, 0, 0);
      s0 = sync_cnt;
      wait_tick();
      Rx_i = 1'b0;
      repeat (3) wait_tick();
      idle(2 * NDIR);
      vec++; if ({p_Empty_o, RxFifoLevel_o} !== {1'b1, 16'd0}) begin miss++;
         $display("FAIL glitch_fifo got empty=%b level=%0d want empty=1 level=0", p_Empty_o, RxFifoLevel_o); end
      vec++; if (sync_cnt !== s0) begin miss++; $display("FAIL glitch_synch got %0d want 0", sync_cnt - s0); end
   endtask

   task automatic test_frame_err_break();
      send_frame(9'h055, 8, 0, 0, 0, 0, 0, 0, 1, NDIR, 0, -1);
      idle(2 * NDIR);
      vec++; if (Data_o !== 9'h055) begin miss++; $display("FAIL ferr_data got %h want 055", Data_o); end
      vec++; if ({p_HeadFrameErr_o, p_HeadParityErr_o} !== 2'b10) begin miss++;
         $display("FAIL ferr_flags got %b want 10", {p_HeadFrameErr_o, p_HeadParityErr_o}); end
      pop();
      wait_tick();
      Rx_i = 1'b0;
      repeat (2 * 10 * NDIR) wait_tick();
      idle(2 * NDIR);
      vec++; if (p_Break_o !== 1'b1) begin miss++; $display("FAIL break_flag got %b want 1", p_Break_o); end
      vec++; if (RxFifoLevel_o !== 16'd0) begin miss++; $display("FAIL break_level got %0d want 0", RxFifoLevel_o); end
      clr();
      vec++; if (p_Break_o !== 1'b0) begin miss++; $display("FAIL break_clear got %b want 0", p_Break_o); end
   endtask

   task automatic test_overflow();
      logic [8:0] b [5] = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
      foreach (b[i]) begin
         send_frame(b[i], 8, 0, 0, 0, 0, 0, 1, 1, NDIR, 0, -1);
         idle(2);
      end
      vec++; if ({p_Full_o, p_Over_o} !== 2'b11) begin miss++;
         $display("FAIL ovf_flags got full=%b over=%b want 11", p_Full_o, p_Over_o); end
      vec++; if (RxFifoLevel_o !== 16'd4) begin miss++; $display("FAIL ovf_level got %0d want 4", RxFifoLevel_o); end
      vec++; if (Data_o !== 9'h011) begin miss++; $display("FAIL ovf_head got %h want 011", Data_o); end
      clr();
      vec++; if ({RxFifoLevel_o, p_Over_o, p_Empty_o} !== {16'd0, 1'b0, 1'b1}) begin miss++;
         $display("FAIL clr_state got level=%0d over=%b empty=%b want 0 0 1", RxFifoLevel_o, p_Over_o, p_Empty_o); end
   endtask

   task automatic test_noise();
      send_frame(9'h03C, 8, 0, 0, 0, 0, 0, 1, 1, NDIR, (NDIR >> 1) + 2, -1);
      idle(2);
      vec++; if ({p_HeadFrameErr_o, p_HeadParityErr_o, Data_o} !== {2'b00, 9'h03C}) begin miss++;
         $display("FAIL noise_word got %b_%b_%h want 0_0_03c", p_HeadFrameErr_o, p_HeadParityErr_o, Data_o); end
      pop();
   endtask

   task automatic test_enable_drop();
      int s0;
      s0 = sync_cnt;
      send_frame(9'h0F0, 8, 0, 0, 0, 0, 0, 1, 1, NDIR, 0, 3);
      idle(2 * NDIR);
      p_Enable_i = 1'b1;
      wait_clks(4);
      vec++; if ({p_Empty_o, RxFifoLevel_o} !== {1'b1, 16'd0}) begin miss++;
         $display("FAIL endrop_fifo got empty=%b level=%0d want 1 0", p_Empty_o, RxFifoLevel_o); end
      vec++; if (sync_cnt !== s0) begin miss++; $display("FAIL endrop_synch got %0d want 0", sync_cnt - s0); end
      send_frame(9'h096, 8, 0, 0, 0, 0, 0, 1, 1, NDIR, 0, -1);
      idle(2);
      vec++; if (Data_o !== 9'h096) begin miss++; $display("FAIL endrop_recover got %h want 096", Data_o); end
      pop();
   endtask

   task automatic test_random();
      for (int f = 0; f < 20; f++) begin
         int n_raw, neff, db_raw, nb, noise, s0;
         bit pe, po, big, two, badp, s1, s2, pbit, brk, ferr, perr;
         logic [8:0] d, dm;
         n_raw  = $urandom_range(15, 0);
         neff   = (n_raw < 4) ? 4 : n_raw;
         db_raw = $urandom_range(15, 0);
         nb     = (db_raw < 5) ? 5 : ((db_raw > 9) ? 9 : db_raw);
         pe = 1'($urandom); po = 1'($urandom); big = 1'($urandom); two = 1'($urandom);
         badp = pe && ($urandom_range(3, 0) == 0);
         s1 = ($urandom_range(4, 0) != 0);
         s2 = ($urandom_range(4, 0) != 0);
         d = 9'($urandom);
         if ($urandom_range(4, 0) == 0) d = '0;
         noise = ($urandom_range(1, 0) == 1) ? (neff >> 1) + 2 : 0;
         dm   = d & 9'((1 << nb) - 1);
         pbit = ^dm ^ po ^ badp;
         brk  = (dm == 0) && (!pe || !pbit) && !s1;
         ferr = !s1 || (two && !s2);
         perr = pe && badp;
         set_fmt(n_raw, db_raw, pe, po, two, big);
         s0 = sync_cnt;
         send_frame(d, nb, pe, po, big, two, badp, s1, s2, neff, noise, -1);
         idle(2 * neff);
         if (brk) begin
            vec++; if ({p_Break_o, RxFifoLevel_o} !== {1'b1, 16'd0}) begin miss++;
               $display("FAIL rnd%0d_break got brk=%b level=%0d want 1 0", f, p_Break_o, RxFifoLevel_o); end
            clr();
         end else begin
            vec++; if (RxFifoLevel_o !== 16'd1) begin miss++;
               $display("FAIL rnd%0d_level got %0d want 1", f, RxFifoLevel_o); end
            vec++; if ({p_HeadFrameErr_o, p_HeadParityErr_o, Data_o} !== {ferr, perr, dm}) begin miss++;
               $display("FAIL rnd%0d_word got %b_%b_%h want %b_%b_%h", f, p_HeadFrameErr_o,
                        p_HeadParityErr_o, Data_o, ferr, perr, dm); end
            vec++; if (sync_cnt !== s0 + 1) begin miss++;
               $display("FAIL rnd%0d_synch got %0d want 1", f, sync_cnt - s0); end
            pop();
         end
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_9o2_msb();
      test_glitch();
      test_frame_err_break();
      test_overflow();
      test_noise();
      test_enable_drop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
`default_nettype wire
